// File: rtl/line_window_3x3_pkg.sv
// Shared sizing defaults and window slice indexing for the padding, window and
// convolution stages.
package line_window_3x3_pkg;

   localparam int unsigned DefD         = 220;
   localparam int unsigned DefDataWidth = 32;
   localparam int unsigned WinTaps      = 9;

   function automatic int unsigned pad_side(input int unsigned d);
      return d + 2;
   endfunction

   // Slice index inside win_out: top row first, left column first.
   function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
      return 3 * r + c;
   endfunction

endpackage

// File: rtl/line_window_3x3_fifo.sv
// line_fifo: circular line buffer returning the entry written Depth writes ago,
// read in the same cycle the slot is overwritten.
module line_fifo #(
   parameter int unsigned Depth = 6,
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic [Width-1:0] wr_data_i,
   output logic [Width-1:0] rd_data_o
);

   localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PW-1:0] PtrMax = PW'(Depth - 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PW-1:0]    ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (wr_en_i) begin
         ptr_d = (ptr_q == PtrMax) ? '0 : ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Storage is left uncleared; downstream gating hides stale entries.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[ptr_q] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[ptr_q];

endmodule

// File: rtl/line_window_3x3.sv
// 3x3 sliding window over a padded raster stream, built from two line buffers
// and a shifting register window.
module line_window_3x3
   import line_window_3x3_pkg::*;
#(
   parameter int unsigned D          = DefD,
   parameter int unsigned DATA_WIDTH = DefDataWidth
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_WIDTH-1:0]         pxl_in,
   input  logic                          valid_in,
   output logic [WinTaps*DATA_WIDTH-1:0] win_out,
   output logic                          valid_out,
   output logic                          frame_done
);

   localparam int unsigned W  = pad_side(D);
   localparam int unsigned H  = pad_side(D);
   localparam int unsigned CW = $clog2(W);
   localparam logic [CW-1:0] ColMax = CW'(W - 1);
   localparam logic [CW-1:0] RowMax = CW'(H - 1);
   localparam logic [CW-1:0] Two    = CW'(2);

   logic [CW-1:0]                 col_q, col_d, row_q, row_d;
   logic [DATA_WIDTH-1:0]         win_q [3][3];
   logic [DATA_WIDTH-1:0]         win_d [3][3];
   logic [WinTaps*DATA_WIDTH-1:0] win_out_q, win_out_d;
   logic                          valid_out_q, valid_out_d;
   logic                          frame_done_q, frame_done_d;
   logic [DATA_WIDTH-1:0]         lb0_rd, lb1_rd;

   // lb0 yields the pixel one row up, lb1 (fed by lb0) the pixel two rows up.
   line_fifo #(.Depth(W), .Width(DATA_WIDTH)) u_lb0 (
      .clk_i     (clk),
      .rst_ni    (reset),
      .wr_en_i   (valid_in),
      .wr_data_i (pxl_in),
      .rd_data_o (lb0_rd)
   );

   line_fifo #(.Depth(W), .Width(DATA_WIDTH)) u_lb1 (
      .clk_i     (clk),
      .rst_ni    (reset),
      .wr_en_i   (valid_in),
      .wr_data_i (lb0_rd),
      .rd_data_o (lb1_rd)
   );

   always_comb begin
      win_d        = win_q;
      col_d        = col_q;
      row_d        = row_q;
      win_out_d    = win_out_q;
      valid_out_d  = 1'b0;
      frame_done_d = 1'b0;
      if (valid_in) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb1_rd;
         win_d[1][2] = lb0_rd;
         win_d[2][2] = pxl_in;

         if (col_q == ColMax) begin
            col_d = '0;
            row_d = (row_q == RowMax) ? '0 : row_q + CW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end

         if (row_q >= Two && col_q >= Two) begin
            valid_out_d = 1'b1;
            for (int r = 0; r < 3; r++) begin
               for (int c = 0; c < 3; c++) begin
                  win_out_d[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win_d[r][c];
               end
            end
         end
         frame_done_d = (row_q == RowMax) && (col_q == ColMax);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q        <= '0;
         row_q        <= '0;
         win_out_q    <= '0;
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_out_q    <= win_out_d;
         valid_out_q  <= valid_out_d;
         frame_done_q <= frame_done_d;
         win_q        <= win_d;
      end
   end

   assign win_out    = win_out_q;
   assign valid_out  = valid_out_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed bench for line_window_3x3 with D=4 (6x6 padded frames), pixel = base+row*16+col.
module tb_line_window_3x3;

   localparam int unsigned D  = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned WP = 6;

   logic          clk;
   logic          reset;
   logic [DW-1:0] pxl_in;
   logic          valid_in;
   logic [71:0]   win_out;
   logic          valid_out;
   logic          frame_done;

   int n_total = 0;
   int n_bad   = 0;
   logic [71:0] last_win;

   line_window_3x3 #(.D(D), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .pxl_in     (pxl_in),
      .valid_in   (valid_in),
      .win_out    (win_out),
      .valid_out  (valid_out),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [71:0] model_win(input int base, input int row, input int col);
      logic [71:0] w;
      w = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w[(3*r+c)*8 +: 8] = 8'(base + (row - 2 + r) * 16 + (col - 2 + c));
         end
      end
      return w;
   endfunction

   // Streams one frame; stop_at >= 0 ends early after that raster index.
   task automatic run_frame(input int base, input int gap_pct, input int stop_at);
      int n_vo;
      int n_fd;
      logic [71:0] w;
      n_vo = 0;
      n_fd = 0;
      for (int row = 0; row < WP; row++) begin
         for (int col = 0; col < WP; col++) begin
            if (row * WP + col > stop_at && stop_at >= 0) return;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
               for (int g = 0; g < $urandom_range(1, 3); g++) begin
                  valid_in = 1'b0;
                  pxl_in   = 8'($urandom);
                  @(posedge clk); #1;
                  chk("idle_vo", valid_out, 1'b0);
                  chk("idle_fd", frame_done, 1'b0);
                  chk("idle_hold", win_out, last_win);
               end
            end
            valid_in = 1'b1;
            pxl_in   = 8'(base + row * 16 + col);
            @(posedge clk); #1;
            n_vo += valid_out;
            n_fd += frame_done;
            if (row >= 2 && col >= 2) begin
               w = model_win(base, row, col);
               chk("vo", valid_out, 1'b1);
               chk("win", win_out, w);
               last_win = w;
               if (base == 0 && row == 2 && col == 2)
                  chk("first_win", win_out, 72'h22_21_20_12_11_10_02_01_00);
               if (base == 0 && row == 5 && col == 5)
                  chk("last_win", win_out, 72'h55_54_53_45_44_43_35_34_33);
            end else begin
               chk("no_vo", valid_out, 1'b0);
               chk("hold", win_out, last_win);
            end
            chk("fd", frame_done, (row == WP - 1 && col == WP - 1) ? 1'b1 : 1'b0);
         end
      end
      chk("vo_count", 72'(n_vo), 72'd16);
      chk("fd_count", 72'(n_fd), 72'd1);
   endtask

   initial begin
      reset    = 1'b0;
      valid_in = 1'b0;
      pxl_in   = '0;
      last_win = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_win", win_out, 72'd0);
      chk("rst_vo", valid_out, 1'b0);
      chk("rst_fd", frame_done, 1'b0);
      reset = 1'b1;

      run_frame(0, 0, -1);       // continuous frame
      run_frame(0, 30, -1);      // random gaps
      run_frame(0, 0, -1);       // back-to-back pair
      run_frame(8'h80, 0, -1);

      // Abort mid-frame right after (3,3) has produced a window.
      run_frame(0, 0, 3 * WP + 3);
      chk("pre_rst_vo", valid_out, 1'b1);
      reset    = 1'b0;
      valid_in = 1'b0;
      #1;
      chk("async_win", win_out, 72'd0);
      chk("async_vo", valid_out, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("held_win", win_out, 72'd0);
      last_win = '0;
      reset    = 1'b1;
      run_frame(0, 0, -1);

      valid_in = 1'b0;
      @(posedge clk); #1;
      chk("tail_vo", valid_out, 1'b0);
      chk("tail_hold", win_out, last_win);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running want=finished");
      $fatal(1);
   end

endmodule
